// File: rtl/tcam_cmd_ctrl.sv
// tcam_cmd_ctrl: host-side command sequencer for the SRAM-based TCAM port (write / search / flush).
// Define TCAM_CTRL_FLUSH_EN to build the FLUSH sweep; otherwise op=2 is answered as a reserved op.
module tcam_cmd_ctrl #(
  parameter int SRCH_LAT   = 1,
  parameter int FLUSH_ROWS = 1024
) (
  input  logic        in_clk,
  input  logic        in_rstn,
  input  logic        in_cmd_valid,
  output logic        out_cmd_ready,
  input  logic [1:0]  in_cmd_op,
  input  logic [27:0] in_cmd_addr,
  input  logic [31:0] in_cmd_wdata,
  input  logic [3:0]  in_cmd_wmask,
  input  logic [4:0]  in_cmd_tag,
  output logic        out_resp_valid,
  input  logic        in_resp_ready,
  output logic [5:0]  out_resp_pma,
  output logic [4:0]  out_resp_tag,
  output logic        out_resp_err,
  output logic        out_tcam_csb,
  output logic        out_tcam_web,
  output logic [3:0]  out_tcam_wmask,
  output logic [27:0] out_tcam_addr,
  output logic [31:0] out_tcam_wdata,
  input  logic [5:0]  in_tcam_pma,
  output logic        out_busy
);

  if (SRCH_LAT < 1 || SRCH_LAT > 7 || FLUSH_ROWS < 2) begin : g_param_chk
    $error("tcam_cmd_ctrl: SRCH_LAT must be 1..7 and FLUSH_ROWS at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_SRCH, S_SWAIT,
`ifdef TCAM_CTRL_FLUSH_EN
    S_FLUSH,
`endif
    S_RESP
  } state_e;

  localparam logic [2:0] LAT_INIT = 3'(SRCH_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [4:0]  tag_q, tag_d;
  logic [5:0]  pma_q, pma_d;
  logic        err_q, err_d;
  logic        csb_q, csb_d, web_q, web_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

`ifdef TCAM_CTRL_FLUSH_EN
  localparam int            FCW      = $clog2(FLUSH_ROWS);
  localparam logic [FCW-1:0] LAST_ROW = FCW'(FLUSH_ROWS - 1);
  logic [FCW-1:0] cnt_q, cnt_d;

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
`ifdef TCAM_CTRL_FLUSH_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (in_cmd_valid) begin
        case (in_cmd_op)
          2'd0:    state_d = S_WR;
          2'd1:    state_d = S_SRCH;
`ifdef TCAM_CTRL_FLUSH_EN
          2'd2: begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
`endif
          default: state_d = S_RESP;
        endcase
      end
      S_WR:   state_d = S_RESP;
      S_SRCH: begin
        state_d = S_SWAIT;
        lat_d   = LAT_INIT;
      end
      // the cycle that sees lat_q==0 is the one that samples the match address
      S_SWAIT: if (lat_q == 3'd0) state_d = S_RESP;
               else               lat_d   = lat_q - 3'd1;
`ifdef TCAM_CTRL_FLUSH_EN
      S_FLUSH: if (cnt_q == LAST_ROW) state_d = S_RESP;
               else                   cnt_d   = cnt_q + FCW'(1);
`endif
      S_RESP:  if (in_resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // TCAM pins are registered, so they are computed from the state being entered.
  always_comb begin
    tag_d   = tag_q;
    pma_d   = pma_q;
    err_d   = err_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = '0;
    wdata_d = '0;
    if (state_q == S_IDLE && in_cmd_valid) begin
      tag_d = in_cmd_tag;
      pma_d = '0;
      err_d = (state_d == S_RESP);
    end
    if (state_q == S_SWAIT && lat_q == 3'd0) pma_d = in_tcam_pma;
    case (state_d)
      S_WR: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = in_cmd_wmask;
        addr_d  = in_cmd_addr;
        wdata_d = in_cmd_wdata;
      end
      S_SRCH: begin
        csb_d  = 1'b0;
        addr_d = in_cmd_addr;
      end
`ifdef TCAM_CTRL_FLUSH_EN
      S_FLUSH: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = 4'hF;
        addr_d  = 28'(cnt_d);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      lat_q   <= '0;
      tag_q   <= '0;
      pma_q   <= '0;
      err_q   <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      lat_q   <= lat_d;
      tag_q   <= tag_d;
      pma_q   <= pma_d;
      err_q   <= err_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_cmd_ready  = (state_q == S_IDLE);
  assign out_busy       = (state_q != S_IDLE);
  assign out_resp_valid = (state_q == S_RESP);
  assign out_resp_pma   = pma_q;
  assign out_resp_tag   = tag_q;
  assign out_resp_err   = err_q;
  assign out_tcam_csb   = csb_q;
  assign out_tcam_web   = web_q;
  assign out_tcam_wmask = wmask_q;
  assign out_tcam_addr  = addr_q;
  assign out_tcam_wdata = wdata_q;

endmodule

// File: tb/tb_tcam_cmd_ctrl.sv
// Directed bench for tcam_cmd_ctrl: two instances (SRCH_LAT=1 and 3) share command fields and
// the TCAM match input; responses are checked against a queue of expected results.
module tb_tcam_cmd_ctrl;
`ifdef TCAM_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int ROWS = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  op;
  logic [27:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [4:0]  tag;
  logic [5:0]  pma_in;

  logic        cmd_valid [2];
  logic        resp_ready [2];
  logic        cmd_ready [2];
  logic        resp_valid [2];
  logic        resp_err [2];
  logic        csb [2];
  logic        web [2];
  logic        busy [2];
  logic [5:0]  resp_pma [2];
  logic [4:0]  resp_tag [2];
  logic [3:0]  t_wmask [2];
  logic [27:0] t_addr [2];
  logic [31:0] t_wdata [2];

  tcam_cmd_ctrl #(.SRCH_LAT(1), .FLUSH_ROWS(ROWS)) u_l1 (
    .in_clk(clk), .in_rstn(rstn),
    .in_cmd_valid(cmd_valid[0]), .out_cmd_ready(cmd_ready[0]),
    .in_cmd_op(op), .in_cmd_addr(addr), .in_cmd_wdata(wdata), .in_cmd_wmask(wmask), .in_cmd_tag(tag),
    .out_resp_valid(resp_valid[0]), .in_resp_ready(resp_ready[0]),
    .out_resp_pma(resp_pma[0]), .out_resp_tag(resp_tag[0]), .out_resp_err(resp_err[0]),
    .out_tcam_csb(csb[0]), .out_tcam_web(web[0]), .out_tcam_wmask(t_wmask[0]),
    .out_tcam_addr(t_addr[0]), .out_tcam_wdata(t_wdata[0]),
    .in_tcam_pma(pma_in), .out_busy(busy[0]));

  tcam_cmd_ctrl #(.SRCH_LAT(3), .FLUSH_ROWS(ROWS)) u_l3 (
    .in_clk(clk), .in_rstn(rstn),
    .in_cmd_valid(cmd_valid[1]), .out_cmd_ready(cmd_ready[1]),
    .in_cmd_op(op), .in_cmd_addr(addr), .in_cmd_wdata(wdata), .in_cmd_wmask(wmask), .in_cmd_tag(tag),
    .out_resp_valid(resp_valid[1]), .in_resp_ready(resp_ready[1]),
    .out_resp_pma(resp_pma[1]), .out_resp_tag(resp_tag[1]), .out_resp_err(resp_err[1]),
    .out_tcam_csb(csb[1]), .out_tcam_web(web[1]), .out_tcam_wmask(t_wmask[1]),
    .out_tcam_addr(t_addr[1]), .out_tcam_wdata(t_wdata[1]),
    .in_tcam_pma(pma_in), .out_busy(busy[1]));

  typedef struct {
    logic [5:0] pma;
    logic [4:0] tag;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vec  = 0;
  int   miss = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Drive a command at a negedge; returns #1 after the accepting edge.
  task automatic issue(input int i, input logic [1:0] o, input logic [27:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, input logic [4:0] tg);
    op = o; addr = a; wdata = wd; wmask = wm; tag = tg;
    cmd_valid[i] = 1'b1;
    chk("accept_ready", cmd_ready[i], 1'b1);
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
  endtask

  task automatic run_cmd(input int i, input logic [1:0] o, input logic [27:0] a,
                         input logic [31:0] wd, input logic [3:0] wm, input logic [4:0] tg,
                         input logic [5:0] pm, input int hold);
    int   L, lat, act_exp, act, bad, early;
    logic e_csb, e_web;
    logic [3:0]  e_wm;
    logic [27:0] e_ad;
    logic [31:0] e_wd;
    exp_t e, got;
    L = (i == 0) ? 1 : 3;
    e.tag = tg; e.pma = 6'd0; e.err = 1'b0;
    case (o)
      2'd0: begin lat = 2; act_exp = 1; end
      2'd1: begin lat = L + 2; act_exp = 1; e.pma = pm; end
      2'd2: begin
        lat     = FLUSH_EN ? ROWS + 1 : 1;
        act_exp = FLUSH_EN ? ROWS : 0;
        e.err   = !FLUSH_EN;
      end
      default: begin lat = 1; act_exp = 0; e.err = 1'b1; end
    endcase
    issue(i, o, a, wd, wm, tg);
    exp_q.push_back(e);
    act = 0; bad = 0; early = 0;
    for (int k = 1; k <= lat; k++) begin
      // match input carries the real answer only in the sample cycle
      pma_in = (k == 1 + L) ? pm : (pm ^ 6'(k));
      @(negedge clk);
      e_csb = 1'b1; e_web = 1'b1; e_wm = '0; e_ad = '0; e_wd = '0;
      if (o == 2'd0 && k == 1) begin e_csb = 0; e_web = 0; e_wm = wm; e_ad = a; e_wd = wd; end
      if (o == 2'd1 && k == 1) begin e_csb = 0; e_ad = a; end
      if (o == 2'd2 && FLUSH_EN && k <= ROWS) begin
        e_csb = 0; e_web = 0; e_wm = 4'hF; e_ad = 28'(k - 1);
      end
      if ({csb[i], web[i], t_wmask[i], t_addr[i], t_wdata[i]} !== {e_csb, e_web, e_wm, e_ad, e_wd})
        bad++;
      if (!csb[i]) act++;
      if (k < lat && resp_valid[i]) early++;
      if (k < lat) begin @(posedge clk); #1; end
    end
    chk("tcam_seq", bad, 0);
    chk("tcam_active", act, act_exp);
    chk("early_resp", early, 0);
    chk("resp_valid", resp_valid[i], 1'b1);
    chk("busy_resp", busy[i], 1'b1);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      chk("resp_pma", resp_pma[i], got.pma);
      chk("resp_tag", resp_tag[i], got.tag);
      chk("resp_err", resp_err[i], got.err);
    end
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        op = 2'd1; addr = 28'h1234567; tag = 5'd0;
        cmd_valid[i] = 1'b1;
        pma_in = 6'($urandom);
        @(negedge clk);
        if (!resp_valid[i] || cmd_ready[i] || !csb[i] ||
            resp_pma[i] !== e.pma || resp_tag[i] !== e.tag || resp_err[i] !== e.err)
          bad++;
      end
      chk("hold_stable", bad, 0);
    end
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", resp_valid[i], 1'b0);
    chk("post_hs_ready", cmd_ready[i], 1'b1);
    chk("post_hs_idle", {busy[i], csb[i]}, 2'b01);
    cmd_valid[i] = 1'b0;
  endtask

  initial begin
    int ai, an, bad;
    op = '0; addr = '0; wdata = '0; wmask = '0; tag = '0; pma_in = '0;
    for (int i = 0; i < 2; i++) begin cmd_valid[i] = 1'b0; resp_ready[i] = 1'b0; end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_csb", csb[i], 1'b1);
      chk("rst_web", web[i], 1'b1);
      chk("rst_wmask", t_wmask[i], 4'h0);
      chk("rst_addr", t_addr[i], 28'h0);
      chk("rst_wdata", t_wdata[i], 32'h0);
      chk("rst_resp_valid", resp_valid[i], 1'b0);
      chk("rst_cmd_ready", cmd_ready[i], 1'b1);
    end
    rstn = 1'b1;

    run_cmd(0, 2'd0, 28'h0000100, 32'hDEADBEEF, 4'hF, 5'd5, 6'd0, 0);
    run_cmd(0, 2'd0, 28'h00003FF, 32'h12345678, 4'h5, 5'd17, 6'd0, 0);
    run_cmd(0, 2'd1, 28'h0ABCDEF, 32'h0, 4'h0, 5'd9, 6'd37, 10);
    run_cmd(1, 2'd1, 28'h0ABCDEF, 32'h0, 4'h0, 5'd10, 6'd37, 0);
    run_cmd(1, 2'd1, 28'hFFFFFFF, 32'h0, 4'h0, 5'd31, 6'd0, 3);
    run_cmd(0, 2'd3, 28'h0000055, 32'hFFFFFFFF, 4'hF, 5'd7, 6'd0, 0);
    run_cmd(1, 2'd2, 28'h0000000, 32'hA5A5A5A5, 4'h3, 5'd12, 6'd0, 0);

    // reset in the middle of a command: pins go idle at once and no response follows
    ai = FLUSH_EN ? 0 : 1;
    an = FLUSH_EN ? 501 : 2;
    issue(ai, FLUSH_EN ? 2'd2 : 2'd1, 28'h0000321, 32'h0, 4'h0, 5'd20);
    for (int k = 1; k <= an; k++) begin
      @(negedge clk);
      if (k < an) begin @(posedge clk); #1; end
    end
`ifdef TCAM_CTRL_FLUSH_EN
    chk("abort_row", t_addr[0], 28'd500);
`endif
    chk("abort_busy", busy[ai], 1'b1);
    rstn = 1'b0;
    #1;
    chk("abort_csb", csb[ai], 1'b1);
    chk("abort_web", web[ai], 1'b1);
    chk("abort_addr", t_addr[ai], 28'h0);
    chk("abort_idle", busy[ai], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid[ai] || busy[ai]) bad++;
    end
    chk("abort_no_resp", bad, 0);
    run_cmd(ai, 2'd1, 28'h0000ABC, 32'h0, 4'h0, 5'd3, 6'd63, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
